regfile_write_arbiter: RTL and testbench

// Owns the single write port of the 8x16 register file. After reset it clears every register
// (CLEAR sequence), then arbitrates between the core writeback path and the debug/load port.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/wr_prio_arb.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the 8x16 register file, its write arbiter and decode.
package regfile_pkg;

   localparam int unsigned WORD_LEN  = 16;
   localparam int unsigned REG_COUNT = 8;
   localparam int unsigned ADDR_W    = 3;

   // r0 is hard-wired to zero; writes to it are dropped
   localparam logic [ADDR_W-1:0] R0_ADDR = 3'd0;

   // Write-port owner state; encoding is fixed (CLEAR=0, RUN=1)
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // Saturating 4-bit increment used by the starvation counter
   function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

// File: rtl/wr_prio_arb.sv
// Combinational two-way write-port arbiter: core has priority unless debug is starved.
module wr_prio_arb (
   input  logic i_en,
   input  logic i_core_valid,
   input  logic i_dbg_valid,
   input  logic i_starved,
   output logic o_core_grant,
   output logic o_dbg_grant
);

   // Grant at most one requester per cycle; nothing is granted while disabled
   always_comb begin
      o_core_grant = 1'b0;
      o_dbg_grant  = 1'b0;
      if (i_en) begin
         if (i_dbg_valid && (!i_core_valid || i_starved)) begin
            o_dbg_grant = 1'b1;
         end else if (i_core_valid) begin
            o_core_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port: clears all registers after reset,
// then arbitrates core writeback and debug/load writes onto registered rf_* outputs.
module regfile_write_arbiter #(
   parameter int unsigned WORD_LEN       = regfile_pkg::WORD_LEN,
   parameter int unsigned REG_COUNT      = regfile_pkg::REG_COUNT,
   parameter int unsigned ADDR_W         = regfile_pkg::ADDR_W,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                core_wr_valid,
   output logic                core_wr_ready,
   input  logic [ADDR_W-1:0]   core_wr_addr,
   input  logic [WORD_LEN-1:0] core_wr_data,
   input  logic                dbg_wr_valid,
   output logic                dbg_wr_ready,
   input  logic [ADDR_W-1:0]   dbg_wr_addr,
   input  logic [WORD_LEN-1:0] dbg_wr_data,
   output logic                rf_regWrite,
   output logic [ADDR_W-1:0]   rf_writeRegister,
   output logic [WORD_LEN-1:0] rf_writeData,
   output logic                init_done,
   output logic                r0_drop
);

   import regfile_pkg::*;

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(REG_COUNT - 1);
   localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(R0_ADDR);

   state_e              r_state;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [CNT_W-1:0]    r_starve;
   logic                r_regwrite;
   logic [ADDR_W-1:0]   r_wreg;
   logic [WORD_LEN-1:0] r_wdata;
   logic                r_init_done;
   logic                r_r0_drop;

   logic                w_run;
   logic                w_starved;
   logic                w_core_grant;
   logic                w_dbg_grant;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [WORD_LEN-1:0] w_sel_data;

   assign w_run     = (r_state == ST_RUN);
   assign w_starved = (r_starve == LIMIT);

   wr_prio_arb u_arb (
      .i_en         (w_run),
      .i_core_valid (core_wr_valid),
      .i_dbg_valid  (dbg_wr_valid),
      .i_starved    (w_starved),
      .o_core_grant (w_core_grant),
      .o_dbg_grant  (w_dbg_grant)
   );

   // Grants only rise for a valid requester, so a grant is an accept
   assign w_accept   = w_core_grant | w_dbg_grant;
   assign w_sel_addr = w_dbg_grant ? dbg_wr_addr : core_wr_addr;
   assign w_sel_data = w_dbg_grant ? dbg_wr_data : core_wr_data;

   assign core_wr_ready    = w_core_grant;
   assign dbg_wr_ready     = w_dbg_grant;
   assign rf_regWrite      = r_regwrite;
   assign rf_writeRegister = r_wreg;
   assign rf_writeData     = r_wdata;
   assign init_done        = r_init_done;
   assign r0_drop          = r_r0_drop;

   // FSM: clear sequence, then registered write of the accepted request plus starvation tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         r_clr_cnt   <= '0;
         r_starve    <= '0;
         r_regwrite  <= 1'b0;
         r_wreg      <= '0;
         r_wdata     <= '0;
         r_init_done <= !CLEAR_ON_RESET;
         r_r0_drop   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_regwrite <= 1'b1;
               r_wreg     <= r_clr_cnt;
               r_wdata    <= '0;
               r_r0_drop  <= 1'b0;
               if (r_clr_cnt == LAST_REG) begin
                  r_clr_cnt <= '0;
                  r_state   <= ST_RUN;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               // Rises one cycle after the final clear write is presented
               r_init_done <= 1'b1;
               r_regwrite  <= 1'b0;
               r_r0_drop   <= 1'b0;
               if (w_accept) begin
                  if (w_sel_addr == ZERO_REG) begin
                     r_r0_drop <= 1'b1;
                  end else begin
                     r_regwrite <= 1'b1;
                     r_wreg     <= w_sel_addr;
                     r_wdata    <= w_sel_data;
                  end
               end
               if (w_dbg_grant || !dbg_wr_valid) begin
                  r_starve <= '0;
               end else if (w_core_grant) begin
                  r_starve <= sat_inc4(r_starve, LIMIT);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (main instance clears on reset,
// second instance starts directly in RUN).
module tb_regfile_write_arbiter;

   localparam int unsigned LIMIT = 4;

   typedef struct {
      logic        drop;
      logic [2:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_wr_valid, core_wr_ready, dbg_wr_valid, dbg_wr_ready;
   logic [2:0]  core_wr_addr, dbg_wr_addr, rf_writeRegister;
   logic [15:0] core_wr_data, dbg_wr_data, rf_writeData;
   logic        rf_regWrite, init_done, r0_drop;

   logic        rst_b;
   logic        core_wr_valid_b, core_wr_ready_b, dbg_wr_valid_b, dbg_wr_ready_b;
   logic [2:0]  core_wr_addr_b, dbg_wr_addr_b, rf_writeRegister_b;
   logic [15:0] core_wr_data_b, dbg_wr_data_b, rf_writeData_b;
   logic        rf_regWrite_b, init_done_b, r0_drop_b;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic        mon_en   = 1'b0;
   exp_t        sb_q[$];
   logic        grant_q[$];
   logic [15:0] rf_model [8];

   always #5 clk = ~clk;

   regfile_write_arbiter #(
      .WORD_LEN(16), .REG_COUNT(8), .ADDR_W(3), .STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
      .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
      .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
      .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
      .rf_regWrite(rf_regWrite), .rf_writeRegister(rf_writeRegister),
      .rf_writeData(rf_writeData), .init_done(init_done), .r0_drop(r0_drop)
   );

   regfile_write_arbiter #(
      .WORD_LEN(16), .REG_COUNT(8), .ADDR_W(3), .STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1'b0)
   ) dut_nc (
      .clk(clk), .rst(rst_b),
      .core_wr_valid(core_wr_valid_b), .core_wr_ready(core_wr_ready_b),
      .core_wr_addr(core_wr_addr_b), .core_wr_data(core_wr_data_b),
      .dbg_wr_valid(dbg_wr_valid_b), .dbg_wr_ready(dbg_wr_ready_b),
      .dbg_wr_addr(dbg_wr_addr_b), .dbg_wr_data(dbg_wr_data_b),
      .rf_regWrite(rf_regWrite_b), .rf_writeRegister(rf_writeRegister_b),
      .rf_writeData(rf_writeData_b), .init_done(init_done_b), .r0_drop(r0_drop_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Register file model: commits at the edge ending the write cycle
   always @(posedge clk) begin
      if (rf_regWrite) rf_model[rf_writeRegister] <= rf_writeData;
   end

   // Scoreboard push: expected rf_* result of each accept, derived from the request
   always @(posedge clk) begin
      exp_t e;
      if (mon_en && !rst) begin
         if (core_wr_valid && core_wr_ready) begin
            e.drop = (core_wr_addr == 3'd0); e.addr = core_wr_addr; e.data = core_wr_data;
            sb_q.push_back(e);
            grant_q.push_back(1'b0);
         end else if (dbg_wr_valid && dbg_wr_ready) begin
            e.drop = (dbg_wr_addr == 3'd0); e.addr = dbg_wr_addr; e.data = dbg_wr_data;
            sb_q.push_back(e);
            grant_q.push_back(1'b1);
         end
      end
   end

   // Scoreboard pop/compare half a cycle after the accepting edge
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         check_eq("one_ready", 32'(core_wr_ready & dbg_wr_ready), 32'd0);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.drop) begin
               check_eq("drop_regwrite", 32'(rf_regWrite), 32'd0);
               check_eq("drop_pulse", 32'(r0_drop), 32'd1);
            end else begin
               check_eq("wr_regwrite", 32'(rf_regWrite), 32'd1);
               check_eq("wr_reg", 32'(rf_writeRegister), 32'(e.addr));
               check_eq("wr_data", 32'(rf_writeData), 32'(e.data));
               check_eq("wr_nodrop", 32'(r0_drop), 32'd0);
            end
         end else begin
            check_eq("idle_regwrite", 32'(rf_regWrite), 32'd0);
            check_eq("idle_drop", 32'(r0_drop), 32'd0);
         end
      end
   end

   task automatic core_write(input logic [2:0] a, input logic [15:0] d);
      logic ok;
      ok = 1'b0;
      core_wr_addr = a; core_wr_data = d; core_wr_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk);
         if (core_wr_ready) ok = 1'b1;
      end
      @(negedge clk);
      core_wr_valid = 1'b0;
      check_eq("core_accept", 32'(ok), 32'd1);
   endtask

   task automatic dbg_write(input logic [2:0] a, input logic [15:0] d);
      logic ok;
      ok = 1'b0;
      dbg_wr_addr = a; dbg_wr_data = d; dbg_wr_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk);
         if (dbg_wr_ready) ok = 1'b1;
      end
      @(negedge clk);
      dbg_wr_valid = 1'b0;
      check_eq("dbg_accept", 32'(ok), 32'd1);
   endtask

   // Called at the negedge where rst was released; valids may be high on entry
   task automatic clear_seq_check();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("clr_regwrite", 32'(rf_regWrite), 32'd1);
         check_eq("clr_reg", 32'(rf_writeRegister), 32'(k));
         check_eq("clr_data", 32'(rf_writeData), 32'd0);
         check_eq("clr_init", 32'(init_done), 32'd0);
         if (k < 7) begin
            check_eq("clr_core_rdy", 32'(core_wr_ready), 32'd0);
            check_eq("clr_dbg_rdy", 32'(dbg_wr_ready), 32'd0);
         end else begin
            core_wr_valid = 1'b0;
            dbg_wr_valid  = 1'b0;
         end
      end
      @(negedge clk);
      check_eq("init_done_rise", 32'(init_done), 32'd1);
      check_eq("post_clr_regwrite", 32'(rf_regWrite), 32'd0);
      for (int r = 0; r < 8; r++) check_eq("rf_cleared", 32'(rf_model[r]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned sv;
      logic        exp_d;
      for (int r = 0; r < 8; r++) rf_model[r] = 16'hA5A5;
      rst = 1'b1; rst_b = 1'b1;
      core_wr_valid = 1'b0; core_wr_addr = '0; core_wr_data = '0;
      dbg_wr_valid  = 1'b0; dbg_wr_addr  = '0; dbg_wr_data  = '0;
      core_wr_valid_b = 1'b0; core_wr_addr_b = '0; core_wr_data_b = '0;
      dbg_wr_valid_b  = 1'b0; dbg_wr_addr_b  = '0; dbg_wr_data_b  = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_regwrite", 32'(rf_regWrite), 32'd0);
      check_eq("rst_reg", 32'(rf_writeRegister), 32'd0);
      check_eq("rst_data", 32'(rf_writeData), 32'd0);
      check_eq("rst_init", 32'(init_done), 32'd0);
      check_eq("rst_drop", 32'(r0_drop), 32'd0);

      // CLEAR with both requesters pending: readies must stay low
      rst = 1'b0;
      core_wr_valid = 1'b1; core_wr_addr = 3'd6; core_wr_data = 16'h6666;
      dbg_wr_valid  = 1'b1; dbg_wr_addr  = 3'd4; dbg_wr_data  = 16'h4444;
      clear_seq_check();
      mon_en = 1'b1;

      // Single core write
      core_write(3'd3, 16'hBEEF);
      @(negedge clk);
      check_eq("rf3_beef", 32'(rf_model[3]), 32'h0000BEEF);

      // Single debug write
      dbg_write(3'd5, 16'h5A5A);
      @(negedge clk);
      check_eq("rf5_5a5a", 32'(rf_model[5]), 32'h00005A5A);

      // Both valid for 10 cycles: starvation forces periodic debug grants
      grant_q.delete();
      core_wr_addr = 3'd1; core_wr_data = 16'hC001; core_wr_valid = 1'b1;
      dbg_wr_addr  = 3'd2; dbg_wr_data  = 16'hD002; dbg_wr_valid  = 1'b1;
      repeat (10) @(negedge clk);
      core_wr_valid = 1'b0; dbg_wr_valid = 1'b0;
      check_eq("grant_count", grant_q.size(), 32'd10);
      sv = 0;
      for (int i = 0; i < 10; i++) begin
         exp_d = (sv == LIMIT);
         sv = exp_d ? 0 : ((sv + 1 > LIMIT) ? LIMIT : sv + 1);
         if (grant_q.size() > 0) check_eq($sformatf("grant%0d", i), 32'(grant_q.pop_front()), 32'(exp_d));
      end
      @(negedge clk);
      check_eq("rf1_c001", 32'(rf_model[1]), 32'h0000C001);
      check_eq("rf2_d002", 32'(rf_model[2]), 32'h0000D002);

      // Write to r0 is dropped but handshake completes
      core_write(3'd0, 16'h1234);
      @(negedge clk);
      check_eq("rf0_zero", 32'(rf_model[0]), 32'd0);
      repeat (2) @(negedge clk);
      mon_en = 1'b0;

      // Reset mid-CLEAR
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("midclr_active", 32'(rf_regWrite), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_regwrite", 32'(rf_regWrite), 32'd0);
      check_eq("async_reg", 32'(rf_writeRegister), 32'd0);
      check_eq("async_init", 32'(init_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_seq_check();

      // No-clear instance: ready right out of reset
      check_eq("nc_rst_init", 32'(init_done_b), 32'd1);
      check_eq("nc_rst_regwrite", 32'(rf_regWrite_b), 32'd0);
      rst_b = 1'b0;
      dbg_wr_addr_b = 3'd7; dbg_wr_data_b = 16'h00FF; dbg_wr_valid_b = 1'b1;
      #1;
      check_eq("nc_dbg_ready", 32'(dbg_wr_ready_b), 32'd1);
      check_eq("nc_core_ready", 32'(core_wr_ready_b), 32'd0);
      @(negedge clk);
      dbg_wr_valid_b = 1'b0;
      check_eq("nc_regwrite", 32'(rf_regWrite_b), 32'd1);
      check_eq("nc_reg", 32'(rf_writeRegister_b), 32'd7);
      check_eq("nc_data", 32'(rf_writeData_b), 32'h000000FF);
      @(negedge clk);
      check_eq("nc_pulse_end", 32'(rf_regWrite_b), 32'd0);
      check_eq("nc_hold_data", 32'(rf_writeData_b), 32'h000000FF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
